// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   statetype : main controller FSM states
//   OP_*      : primary opcodes (instr[31:26]) the controller understands
//   ALUOP_*   : 2-bit aluop codes consumed by aludec
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle MIPS core.
// Sequences PC / memory / IR / register file / ALU through fetch, decode,
// execute, memory and writeback steps, stalling on memready.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   op, zero, memready : opcode from IR, ALU zero flag, memory done
//   memreq, memwrite   : memory request / write strobe
//   irwrite, regwrite  : IR load, register file write
//   pcen               : PC load (pcwrite | branch & zero)
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc : datapath mux selects
//   aluop              : to aludec (add / sub / funct)
//   illegal            : one-cycle pulse in DECODE for unsupported opcode
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  statetype state, nxt;
  logic     pcwrite, branch, irw, rw, mw;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      FETCH:   if (memready) nxt = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = FETCH;
        endcase
      // Only lw/sw reach MEMADR, so anything but lw is a store.
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memready) nxt = MEMWB;
      MEMWR:   if (memready) nxt = FETCH;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    memreq   = 1'b0;
    mw       = 1'b0;
    irw      = 1'b0;
    rw       = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    case (state)
      FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        irw     = memready;
        pcwrite = memready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        rw       = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memreq = 1'b1;
        mw     = 1'b1;
        iord   = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        rw     = 1'b1;
        regdst = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: rw = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are suppressed while reset is high so nothing is committed
  // in the reset cycle, even if reset lands mid-stall.
  assign irwrite  = irw & ~reset;
  assign regwrite = rw & ~reset;
  assign memwrite = mw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed steps then random instructions, each
// cycle compared against the expected control word derived from the
// instruction class, its stall counts and the zero flag.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset, zero, memready;
  logic [5:0] op;
  logic       memreq, memwrite, irwrite, regwrite, pcen, iord, memtoreg;
  logic       regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .pcen(pcen), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .illegal(illegal)
  );

  // Control word: memreq memwrite irwrite regwrite pcen iord memtoreg regdst
  //               alusrca alusrcb[2] pcsrc[2] aluop[2] illegal
  logic [15:0] obs;
  assign obs = {memreq, memwrite, irwrite, regwrite, pcen, iord, memtoreg,
                regdst, alusrca, alusrcb, pcsrc, aluop, illegal};

  function automatic logic [15:0] mk(
    logic mrq, logic mwr, logic irw, logic rw, logic pce, logic iod,
    logic m2r, logic rdst, logic sa, logic [1:0] sb, logic [1:0] ps,
    logic [1:0] ao, logic ill);
    return {mrq, mwr, irw, rw, pce, iod, m2r, rdst, sa, sb, ps, ao, ill};
  endfunction

  // Instruction classes: 0 lw, 1 sw, 2 rtype, 3 beq, 4 addi, 5 j, 6 illegal
  function automatic int kind_of(logic [5:0] o);
    if (o == 6'b100011) return 0;
    if (o == 6'b101011) return 1;
    if (o == 6'b000000) return 2;
    if (o == 6'b000100) return 3;
    if (o == 6'b001000) return 4;
    if (o == 6'b000010) return 5;
    return 6;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, check the control word, advance.
  task automatic step(string tag, logic mr, logic z, logic [15:0] exp);
    memready = mr;
    zero     = z;
    #1;
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-phase control words.
  function automatic logic [15:0] w_fetch(logic mr);
    return mk(1, 0, mr, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  endfunction

  // Runs one instruction from FETCH back to the next FETCH.
  task automatic do_instr(logic [5:0] o, int fst, int mst, logic bz);
    int k;
    k  = kind_of(o);
    op = o;
    for (int i = 0; i < fst; i++) step("fetch_stall", 1'b0, rb(), w_fetch(1'b0));
    step("fetch", 1'b1, rb(), w_fetch(1'b1));
    step("decode", rb(), rb(),
         mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, k == 6));
    case (k)
      0, 1: begin
        step("memadr", rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
        for (int i = 0; i <= mst; i++)
          step(k == 0 ? "memrd" : "memwr", i == mst, rb(),
               mk(1, k == 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        if (k == 0)
          step("memwb", rb(), rb(), mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      2: begin
        step("execute", rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0));
        step("aluwb", rb(), rb(), mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      3: step("branch", rb(), bz, mk(0, 0, 0, 0, bz, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0));
      4: begin
        step("addiex", rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
        step("addiwb", rb(), rb(), mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      5: step("jump", rb(), rb(), mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0));
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ro;
    int         sel;
    reset = 1'b1; memready = 1'b1; zero = 1'b0; op = 6'b000000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset", obs, w_fetch(1'b1));

    // Directed cases.
    do_instr(6'b100011, 0, 0, 1'b0);   // lw, no wait
    do_instr(6'b101011, 0, 3, 1'b0);   // sw, 3-cycle stall in MEMWR
    do_instr(6'b000100, 0, 0, 1'b1);   // beq taken
    do_instr(6'b000100, 0, 0, 1'b0);   // beq not taken
    do_instr(6'b000000, 0, 0, 1'b0);   // R-type
    do_instr(6'b001000, 0, 0, 1'b0);   // addi
    do_instr(6'b000010, 0, 0, 1'b0);   // j
    do_instr(6'b111111, 0, 0, 1'b0);   // illegal
    do_instr(6'b100011, 2, 1, 1'b0);   // lw with fetch and read stalls

    // Reset while stalled in MEMRD.
    op = 6'b100011;
    step("rst_fetch", 1'b1, 1'b0, w_fetch(1'b1));
    step("rst_decode", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    step("rst_memadr", 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
    step("rst_memrd", 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    reset = 1'b1; memready = 1'b1;
    #1 chk("rst_nowrite", {14'b0, regwrite, memwrite}, 16'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("rst_to_fetch", obs, w_fetch(1'b1));

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: ro = 6'b100011;
        1: ro = 6'b101011;
        2: ro = 6'b000000;
        3: ro = 6'b000100;
        4: ro = 6'b001000;
        5: ro = 6'b000010;
        6: ro = 6'($urandom_range(0, 63));
        default: ro = 6'b111111;
      endcase
      do_instr(ro, $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Main control FSM for the multicycle MIPS core. It sequences the shared datapath (PC, memory port, IR, register file, single ALU) through fetch, decode, execute, memory and writeback steps, decoding `op` and producing every datapath enable and mux select. It also supplies the 2-bit `aluop` that the existing `aludec` expands into `alucontrol`. Memory access uses a ready handshake, so the FSM stalls on slow memory.

## Interface
- No parameters. Opcodes and state encoding come from the shared package.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: `instr[31:26]` from IR.
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory completed the current access this cycle.
- `memreq` out 1: memory access requested (FETCH, MEMRD, MEMWR).
- `memwrite` out 1: write strobe (MEMWR only).
- `irwrite` out 1: load IR.
- `regwrite` out 1: register file write.
- `pcen` out 1: PC load, equal to `pcwrite | (branch & zero)`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memtoreg` out 1: writeback source, 1 = memory data.
- `regdst` out 1: destination, 1 = rd, 0 = rt.
- `alusrca` out 1: ALU A, 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: PC source, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- All outputs are decoded from state. Some are gated by `memready`/`zero` combinationally.
- Any output not listed for a state is 0.
- **FETCH**: `memreq`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwrite` = `pcwrite` = `memready`.
  - Advance to DECODE only when `memready` is high; otherwise hold.
- **DECODE**: `alusrca`=0, `alusrcb`=11, `aluop`=00 (branch target into ALUOut). Next state by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - Anything else → FETCH, with `illegal`=1 for that cycle.
- **MEMADR**: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next is MEMRD for lw, MEMWR for sw.
- **MEMRD**: `memreq`=1, `iord`=1. Hold until `memready`, then go to MEMWB.
- **MEMWB**: `regwrite`=1, `memtoreg`=1, `regdst`=0. Then FETCH.
- **MEMWR**: `memreq`=1, `memwrite`=1, `iord`=1. Hold until `memready`, then FETCH.
- **EXECUTE**: `alusrca`=1, `alusrcb`=00, `aluop`=10. Then ALUWB.
- **ALUWB**: `regwrite`=1, `regdst`=1, `memtoreg`=0. Then FETCH.
- **BRANCH**: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1 (internal), so `pcen`=`zero`. Then FETCH.
- **ADDIEX**: `alusrca`=1, `alusrcb`=10, `aluop`=00. Then ADDIWB.
- **ADDIWB**: `regwrite`=1, `regdst`=0. Then FETCH.
- **JUMP**: `pcsrc`=10, `pcwrite`=1. Then FETCH.

## Timing
- State register updates on `posedge clk`.
- `reset`=1 at an edge forces FETCH regardless of state, including mid-stall in MEMRD/MEMWR. No write of any kind is committed in the reset cycle.
- Output values while `reset` is high are don't-care.
- After reset the outputs are FETCH values: `memreq`=1, `alusrcb`=01, and `irwrite`/`pcen` follow `memready`. Every other output is 0.
- With `memready` tied high, cycles per instruction are:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - addi 4
  - j 3
  - illegal opcode 2
- Each low-`memready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay stable during the stall.
- `memwrite` stays asserted through a MEMWR stall. Memory commits on the cycle `memready`=1.
- `illegal` is high only in the DECODE cycle that sees the bad opcode.

## Structure
- Shared package `mips_pkg` holds:
  - `typedef enum logic [3:0] statetype` with the 12 states.
  - Opcode constants `OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_ADDI`, `OP_J`.
  - `aluop` constants `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`.
- One module, no sub-module. It has a state register, a next-state always_comb, and an output-decode always_comb.
- `aludec` stays a sibling in the controller wrapper and consumes `aluop`.

## Test plan
- **Reset**: hold `reset` 2 cycles with `memready`=1 → state FETCH, `memreq`=1, `alusrcb`=01, `irwrite`=1, `pcen`=1, `regwrite`=0, `memwrite`=0.
- **lw, no wait**: `op`=100011, `memready`=1 → FETCH→DECODE→MEMADR→MEMRD→MEMWB over 5 cycles. In MEMWB, `regwrite`=1, `memtoreg`=1, `regdst`=0.
- **sw with stall**: `op`=101011, `memready` low for 3 cycles in MEMWR → `memwrite`=1 and `iord`=1 held for 4 cycles, then FETCH. Total 7 cycles.
- **beq**:
  - `zero`=1 → BRANCH has `pcen`=1, `pcsrc`=01, `aluop`=01.
  - Repeat with `zero`=0 → `pcen`=0.
  - Both take 3 cycles.
- **R-type, addi, j**:
  - R-type: `op`=000000 → EXECUTE `aluop`=10, then ALUWB `regdst`=1.
  - addi: `op`=001000 → ADDIWB `regdst`=0.
  - j: `op`=000010 → JUMP `pcsrc`=10, `pcen`=1.
- **Illegal and mid-stall reset**:
  - `op`=111111 → `illegal` pulses 1 cycle in DECODE, then FETCH.
  - Assert `reset` while stalled in MEMRD → FETCH next cycle, no `regwrite`.
